// File: rtl/number_display_renderer.sv
// number_display_renderer: double-dabble value-to-BCD converter with atomic digit shadow, plus a
// 2-stage pixel lookup into a shared glyph ROM. `LEADING_ZERO_BLANK_EN enables leading-zero blanking.

module font_digits_pixelmap #(
  parameter int unsigned ROM_AW = 13,
  parameter int unsigned DATA_W = 6
) (
  input  logic              iClock,
  input  logic              iResetN,
  input  logic [ROM_AW-1:0] iAddr,
  output logic [DATA_W-1:0] oData
);
  logic [ROM_AW-1:0] addrQ;

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) addrQ <= '0;
    else          addrQ <= iAddr;
  end

  // Procedural content generator standing in for the glyph bitmap of digits 0..9
  always_comb oData = DATA_W'(addrQ) ^ DATA_W'(addrQ >> 6) ^ DATA_W'(addrQ >> 9) ^ DATA_W'(6'h2A);
endmodule

module number_display_renderer #(
  parameter int unsigned VALUE_W  = 16,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned FONT_W   = 16,
  parameter int unsigned FONT_H   = 32,
  parameter int unsigned ROM_AW   = 13,
  parameter int unsigned BG_INDEX = 0
) (
  input  logic               iClock,
  input  logic               iResetN,
  input  logic [VALUE_W-1:0] iValue,
  input  logic               iLoad,
  output logic               oBusy,
  output logic               oDone,
  input  logic               iPixelValid,
  input  logic [9:0]         iPixelX,
  input  logic [9:0]         iPixelY,
  output logic               oPixelValid,
  output logic [5:0]         oColorIndex
);
  localparam int unsigned BCD_RAW = (VALUE_W * 3) / 10 + 2;
  localparam int unsigned BCD_N   = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
  localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
  localparam int unsigned BOX_W   = DIGITS * FONT_W;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] SAT_LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} stateT;

  stateT                 state, stateNext;
  logic                  loadAccept, doShift, doCommit;
  logic [VALUE_W-1:0]    bin;
  logic [4*BCD_N-1:0]    bcd, bcdAdj;
  logic [CNT_W-1:0]      count;
  logic                  sat;
  logic [4*DIGITS-1:0]   shadow, commitDigits;
  logic [DIGITS-1:0]     blank, blankNext;

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    loadAccept = 1'b0;
    doShift    = 1'b0;
    doCommit   = 1'b0;
    case (state)
      IDLE: if (iLoad) begin
        loadAccept = 1'b1;
        stateNext  = SHIFT;
      end
      SHIFT: begin
        doShift = 1'b1;
        if (count == CNT_W'(1)) stateNext = COMMIT;
      end
      COMMIT: begin
        doCommit  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Double-dabble correction: bias every nibble >= 5 before the shift
  always_comb begin
    bcdAdj = bcd;
    for (int unsigned i = 0; i < BCD_N; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  assign commitDigits = sat ? {DIGITS{4'd9}} : bcd[4*DIGITS-1:0];

`ifdef LEADING_ZERO_BLANK_EN
  logic seenNonZero;
  always_comb begin
    blankNext   = '0;
    seenNonZero = 1'b0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (commitDigits[4*i +: 4] != 4'd0) seenNonZero = 1'b1;
      blankNext[i] = !seenNonZero;
    end
  end
`else
  assign blankNext = '0;
`endif

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      bin    <= '0;
      bcd    <= '0;
      count  <= '0;
      sat    <= 1'b0;
      shadow <= '0;
      blank  <= '0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      oBusy <= (stateNext != IDLE);
      oDone <= doCommit;
      if (loadAccept) begin
        bin   <= iValue;
        bcd   <= '0;
        count <= CNT_W'(VALUE_W);
        sat   <= (64'(iValue) >= SAT_LIMIT);
      end
      if (doShift) begin
        bcd   <= {bcdAdj[4*BCD_N-2:0], bin[VALUE_W-1]};
        bin   <= bin << 1;
        count <= count - CNT_W'(1);
      end
      if (doCommit) begin
        shadow <= commitDigits;
        blank  <= blankNext;
      end
    end
  end

  // Pixel stage 0: locate digit and glyph column, form ROM address
  logic [9:0]        digitIdx, col;
  logic              inBox, blankSel;
  logic [3:0]        glyph;
  logic [ROM_AW-1:0] romAddr;
  logic [5:0]        romQ;

  assign digitIdx = iPixelX / 10'(FONT_W);
  assign col      = iPixelX - 10'(digitIdx * 10'(FONT_W));
  assign inBox    = (32'(iPixelX) < BOX_W) && (32'(iPixelY) < FONT_H);

  always_comb begin
    glyph    = '0;
    blankSel = 1'b0;
    romAddr  = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (digitIdx == 10'(i)) begin
        glyph    = shadow[4*(DIGITS-1-i) +: 4];
        blankSel = blank[DIGITS-1-i];
      end
    if (inBox)
      romAddr = ROM_AW'(glyph) * ROM_AW'(FONT_W * FONT_H) + ROM_AW'(iPixelY) * ROM_AW'(FONT_W)
              + ROM_AW'(col);
  end

  font_digits_pixelmap #(.ROM_AW(ROM_AW), .DATA_W(6)) uRom (
    .iClock (iClock),
    .iResetN(iResetN),
    .iAddr  (romAddr),
    .oData  (romQ)
  );

  logic s1Valid, s1InBox, s1Blank;

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      s1Valid     <= 1'b0;
      s1InBox     <= 1'b0;
      s1Blank     <= 1'b0;
      oPixelValid <= 1'b0;
      oColorIndex <= 6'(BG_INDEX);
    end else begin
      s1Valid     <= iPixelValid;
      s1InBox     <= inBox;
      s1Blank     <= blankSel;
      oPixelValid <= s1Valid;
      if (s1Valid) oColorIndex <= (s1InBox && !s1Blank) ? romQ : 6'(BG_INDEX);
    end
  end
endmodule

// File: tb/tb_number_display_renderer.sv
// Directed bench for number_display_renderer: a default instance and a DIGITS=4 instance share stimulus.
module tb_number_display_renderer;
  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] value;
  logic        load;
  logic        pixelValid;
  logic [9:0]  pixelX, pixelY;
  logic        busy, done, pv;
  logic [5:0]  ci;
  logic        busy4, done4, pv4;
  logic [5:0]  ci4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  number_display_renderer dut (
    .iClock(clk), .iResetN(rstN), .iValue(value), .iLoad(load), .oBusy(busy), .oDone(done),
    .iPixelValid(pixelValid), .iPixelX(pixelX), .iPixelY(pixelY),
    .oPixelValid(pv), .oColorIndex(ci)
  );

  number_display_renderer #(.DIGITS(4)) dut4 (
    .iClock(clk), .iResetN(rstN), .iValue(value), .iLoad(load), .oBusy(busy4), .oDone(done4),
    .iPixelValid(pixelValid), .iPixelX(pixelX), .iPixelY(pixelY),
    .oPixelValid(pv4), .oColorIndex(ci4)
  );

  // Glyph ROM contents as defined for font_digits_pixelmap
  function automatic logic [5:0] romModel(input int a);
    return 6'((a & 63) ^ ((a >> 6) & 63) ^ ((a >> 9) & 63) ^ 42);
  endfunction

  task automatic readPixel(input int x, input int y);
    pixelValid = 1'b1;
    pixelX = 10'(x);
    pixelY = 10'(y);
    @(posedge clk); #1;
    pixelValid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic loadSeq(input int v1, input int v2, input int gap,
                         output int firstDone, output int firstDone4, output int pulses,
                         output logic busyAt1);
    value = 16'(v1);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    firstDone = -1;
    firstDone4 = -1;
    pulses = 0;
    busyAt1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (gap > 0 && c == gap) begin
        value = 16'(v2);
        load = 1'b1;
      end
      @(posedge clk); #1;
      load = 1'b0;
      if (c == 1) busyAt1 = busy;
      if (done) begin
        pulses++;
        if (firstDone < 0) firstDone = c;
      end
      if (done4 && firstDone4 < 0) firstDone4 = c;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; load = 1'b0; value = '0; pixelValid = 1'b0; pixelX = '0; pixelY = '0;
    #12;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (pv !== 1'b0) $display("FAIL reset_pv got %b want 0", pv); else passed++;
    checks++; if (ci !== 6'd0) $display("FAIL reset_ci got %0d want 0", ci); else passed++;
    @(posedge clk); #1 rstN = 1'b1;
    pixelValid = 1'b1; pixelX = 10'd5; pixelY = 10'd3;
    value = 16'd12345; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL pre_busy got %b want 1", busy); else passed++;
    checks++; if (ci !== romModel(53)) $display("FAIL pre_ci got %0d want %0d", ci, romModel(53)); else passed++;
    #2 rstN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL midreset_done got %b want 0", done); else passed++;
    checks++; if (pv !== 1'b0 || pv4 !== 1'b0) $display("FAIL midreset_pv got %b/%b want 0/0", pv, pv4); else passed++;
    checks++; if (ci !== 6'd0) $display("FAIL midreset_ci got %0d want 0", ci); else passed++;
    pixelValid = 1'b0;
    @(posedge clk); #1 rstN = 1'b1;
    readPixel(5, 3);
    checks++; if (pv !== 1'b1 || ci !== romModel(53)) $display("FAIL zero_d0 got %b/%0d want 1/%0d", pv, ci, romModel(53)); else passed++;
    readPixel(20, 3);
    checks++; if (ci !== romModel(52)) $display("FAIL zero_d1 got %0d want %0d", ci, romModel(52)); else passed++;
  endtask

  task automatic test_load_12345();
    int fd, fd4, np;
    logic b1;
    loadSeq(12345, 0, 0, fd, fd4, np, b1);
    checks++; if (fd !== 17) $display("FAIL done_latency got %0d want 17", fd); else passed++;
    checks++; if (np !== 1) $display("FAIL done_pulses got %0d want 1", np); else passed++;
    checks++; if (b1 !== 1'b1) $display("FAIL busy_after_load got %b want 1", b1); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_idle got %b want 0", busy); else passed++;
    readPixel(0, 0);
    checks++; if (ci !== romModel(512)) $display("FAIL p_0_0 got %0d want %0d", ci, romModel(512)); else passed++;
    readPixel(79, 31);
    checks++; if (ci !== romModel(3071)) $display("FAIL p_79_31 got %0d want %0d", ci, romModel(3071)); else passed++;
    readPixel(32, 10);
    checks++; if (ci !== romModel(1696)) $display("FAIL p_32_10 got %0d want %0d", ci, romModel(1696)); else passed++;
    readPixel(80, 0);
    checks++; if (pv !== 1'b1 || ci !== 6'd0) $display("FAIL p_80_0 got %b/%0d want 1/0", pv, ci); else passed++;
    readPixel(3, 32);
    checks++; if (ci !== 6'd0) $display("FAIL p_3_32 got %0d want 0", ci); else passed++;
  endtask

  task automatic test_stream();
    localparam int N = 220;
    logic vIn [N];
    int xs [N];
    int ys [N];
    logic [5:0] lastColor;
    int k, g;
    for (int i = 0; i < N; i++) begin
      vIn[i] = (i < 200) ? 1'b1 : ((i % 3) != 0);
      xs[i] = 14 + (i % 4);
      ys[i] = i % 32;
    end
    lastColor = ci;
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        pixelValid = vIn[i]; pixelX = 10'(xs[i]); pixelY = 10'(ys[i]);
      end else pixelValid = 1'b0;
      @(posedge clk); #1;
      if (i >= 1) begin
        k = i - 1;
        checks++; if (pv !== vIn[k]) $display("FAIL stream_valid[%0d] got %b want %b", k, pv, vIn[k]); else passed++;
        if (vIn[k]) begin
          g = (xs[k] < 16) ? 1 : 2;
          lastColor = romModel(g * 512 + ys[k] * 16 + (xs[k] % 16));
        end
        checks++; if (ci !== lastColor) $display("FAIL stream_color[%0d] got %0d want %0d", k, ci, lastColor); else passed++;
      end
    end
  endtask

  task automatic test_saturate();
    int fd, fd4, np;
    logic b1;
    loadSeq(65535, 0, 0, fd, fd4, np, b1);
    checks++; if (fd4 !== 17) $display("FAIL sat_latency got %0d want 17", fd4); else passed++;
    readPixel(0, 0);
    checks++; if (ci4 !== romModel(4608)) $display("FAIL sat_0_0 got %0d want %0d", ci4, romModel(4608)); else passed++;
    readPixel(63, 31);
    checks++; if (ci4 !== romModel(5119)) $display("FAIL sat_63_31 got %0d want %0d", ci4, romModel(5119)); else passed++;
    readPixel(20, 7);
    checks++; if (ci4 !== romModel(4724)) $display("FAIL sat_20_7 got %0d want %0d", ci4, romModel(4724)); else passed++;
    readPixel(64, 0);
    checks++; if (pv4 !== 1'b1 || ci4 !== 6'd0) $display("FAIL sat_64_0 got %b/%0d want 1/0", pv4, ci4); else passed++;
    checks++; if (ci !== romModel(2560)) $display("FAIL full_64_0 got %0d want %0d", ci, romModel(2560)); else passed++;
  endtask

  task automatic test_back_to_back();
    int fd, fd4, np;
    logic b1;
    loadSeq(42, 7, 3, fd, fd4, np, b1);
    checks++; if (fd !== 17) $display("FAIL b2b_latency got %0d want 17", fd); else passed++;
    checks++; if (np !== 1) $display("FAIL b2b_pulses got %0d want 1", np); else passed++;
    readPixel(48, 0);
    checks++; if (ci !== romModel(2048)) $display("FAIL b2b_48_0 got %0d want %0d", ci, romModel(2048)); else passed++;
    readPixel(64, 0);
    checks++; if (ci !== romModel(1024)) $display("FAIL b2b_64_0 got %0d want %0d", ci, romModel(1024)); else passed++;
    readPixel(32, 0);
    checks++; if (ci4 !== romModel(2048)) $display("FAIL b2b4_32_0 got %0d want %0d", ci4, romModel(2048)); else passed++;
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero_blank();
    int fd, fd4, np;
    logic b1;
    readPixel(0, 0);
    checks++; if (ci !== 6'd0) $display("FAIL blank42_0_0 got %0d want 0", ci); else passed++;
    readPixel(47, 5);
    checks++; if (ci !== 6'd0) $display("FAIL blank42_47_5 got %0d want 0", ci); else passed++;
    readPixel(48, 0);
    checks++; if (ci !== romModel(2048)) $display("FAIL blank42_48_0 got %0d want %0d", ci, romModel(2048)); else passed++;
    loadSeq(0, 0, 0, fd, fd4, np, b1);
    checks++; if (fd !== 17) $display("FAIL blank0_latency got %0d want 17", fd); else passed++;
    readPixel(48, 0);
    checks++; if (ci !== 6'd0) $display("FAIL blank0_48_0 got %0d want 0", ci); else passed++;
    readPixel(63, 31);
    checks++; if (ci !== 6'd0) $display("FAIL blank0_63_31 got %0d want 0", ci); else passed++;
    readPixel(64, 0);
    checks++; if (ci !== romModel(0)) $display("FAIL blank0_64_0 got %0d want %0d", ci, romModel(0)); else passed++;
    readPixel(79, 31);
    checks++; if (ci !== romModel(511)) $display("FAIL blank0_79_31 got %0d want %0d", ci, romModel(511)); else passed++;
  endtask
`else
  task automatic test_leading_zeros();
    readPixel(0, 0);
    checks++; if (ci !== romModel(0)) $display("FAIL lz_0_0 got %0d want %0d", ci, romModel(0)); else passed++;
    readPixel(16, 5);
    checks++; if (ci !== romModel(80)) $display("FAIL lz_16_5 got %0d want %0d", ci, romModel(80)); else passed++;
  endtask
`endif

  task automatic test_load_in_commit();
    int fd, fd4, np;
    logic b1;
    loadSeq(9, 3, 17, fd, fd4, np, b1);
    checks++; if (np !== 1) $display("FAIL commit_pulses got %0d want 1", np); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL commit_busy got %b want 0", busy); else passed++;
    readPixel(64, 0);
    checks++; if (ci !== romModel(4608)) $display("FAIL commit_64_0 got %0d want %0d", ci, romModel(4608)); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_12345();
    test_stream();
    test_saturate();
    test_back_to_back();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero_blank();
`else
    test_leading_zeros();
`endif
    test_load_in_commit();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
